// File: rtl/opsg_tone_bank.sv
// opsg_tone_bank
// ---------------------------------------------------------------------------
// A bank of NUM_CH square-wave tone generators for the OPSG sound path. Each
// channel has a frequency register and a down-counter. Both advance on the
// shared ce tick. When a counter reaches zero it reloads from its frequency
// register and flips that channel's output bit. A frequency of zero parks the
// output at 1, which sample playback relies on.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   ce           tick enable; counters advance only while high
//   phase_sync   synchronous restart of every channel (counters 0, bits 1)
//   wr_en        frequency write strobe
//   wr_ch        channel index for the write (>= NUM_CH is ignored)
//   wr_data      new frequency value
//   rd_ch        channel index for counter readback
//   rd_count     registered counter of rd_ch, sampled before this edge's update
//   tone_bits    square-wave output, bit i = channel i
//   toggle_pulse one-clock strobe per channel, aligned with the new tone bit
//
// Priority per channel, highest first: rst_n, phase_sync, write-reload
// (RELOAD_ON_WRITE=1 only), ce advance. Every output is a flop, so there is
// no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module opsg_tone_bank #(
  parameter int TONE_WIDTH      = 10,
  parameter int NUM_CH          = 3,
  parameter int CH_BITS         = 2,
  parameter int RELOAD_ON_WRITE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  phase_sync,
  input  logic                  wr_en,
  input  logic [CH_BITS-1:0]    wr_ch,
  input  logic [TONE_WIDTH-1:0] wr_data,
  input  logic [CH_BITS-1:0]    rd_ch,
  output logic [TONE_WIDTH-1:0] rd_count,
  output logic [NUM_CH-1:0]     tone_bits,
  output logic [NUM_CH-1:0]     toggle_pulse
);

  localparam logic [TONE_WIDTH-1:0] CNT_ZERO = {TONE_WIDTH{1'b0}};
  localparam logic [TONE_WIDTH-1:0] CNT_ONE  = {{(TONE_WIDTH-1){1'b0}}, 1'b1};

  logic [TONE_WIDTH-1:0] freq_r    [NUM_CH];
  logic [TONE_WIDTH-1:0] cnt_r     [NUM_CH];
  logic [TONE_WIDTH-1:0] freq_nx_s [NUM_CH];
  logic [TONE_WIDTH-1:0] cnt_nx_s  [NUM_CH];
  logic [NUM_CH-1:0]     tone_nx_s;
  logic [NUM_CH-1:0]     pulse_nx_s;
  logic [NUM_CH-1:0]     wr_hit_s;
  logic [TONE_WIDTH-1:0] rd_nx_s;

  // Decode the write strobe into a per-channel hit. An out-of-range wr_ch
  // matches no channel, so such a write changes nothing.
  always_comb begin
    wr_hit_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && (wr_ch == CH_BITS'(i))) begin
        wr_hit_s[i] = 1'b1;
      end else begin
        wr_hit_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic for the frequency registers, counters, tone bits and
  // toggle strobes.
  always_comb begin
    tone_nx_s  = tone_bits;
    pulse_nx_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      // The frequency register is written whatever the counter does. A reload
      // on the same edge still reads freq_r, which is the old value.
      if (wr_hit_s[i]) begin
        freq_nx_s[i] = wr_data;
      end else begin
        freq_nx_s[i] = freq_r[i];
      end

      cnt_nx_s[i] = cnt_r[i];
      if (phase_sync) begin
        cnt_nx_s[i]  = CNT_ZERO;
        tone_nx_s[i] = 1'b1;
      end else if ((RELOAD_ON_WRITE != 0) && wr_hit_s[i]) begin
        // A write-reload replaces this edge's tick. The bit holds and no
        // strobe is raised.
        cnt_nx_s[i] = wr_data;
      end else if (ce) begin
        if (cnt_r[i] != CNT_ZERO) begin
          cnt_nx_s[i] = cnt_r[i] - CNT_ONE;
        end else begin
          // Reload on zero. The counter never wraps below zero.
          cnt_nx_s[i] = freq_r[i];
          if (freq_r[i] == CNT_ZERO) begin
            tone_nx_s[i] = 1'b1;
          end else begin
            tone_nx_s[i]  = ~tone_bits[i];
            pulse_nx_s[i] = 1'b1;
          end
        end
      end else begin
        cnt_nx_s[i] = cnt_r[i];
      end
    end
  end

  // Readback mux. An rd_ch with no matching channel reads as zero.
  always_comb begin
    rd_nx_s = CNT_ZERO;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_BITS'(i)) begin
        rd_nx_s = cnt_r[i];
      end else begin
        rd_nx_s = rd_nx_s;
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        freq_r[i] <= CNT_ZERO;
        cnt_r[i]  <= CNT_ZERO;
      end
      tone_bits    <= {NUM_CH{1'b1}};
      toggle_pulse <= {NUM_CH{1'b0}};
      rd_count     <= CNT_ZERO;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        freq_r[i] <= freq_nx_s[i];
        cnt_r[i]  <= cnt_nx_s[i];
      end
      tone_bits    <= tone_nx_s;
      toggle_pulse <= pulse_nx_s;
      rd_count     <= rd_nx_s;
    end
  end

endmodule

// File: tb/tb_opsg_tone_bank.sv
// Directed and random checks of opsg_tone_bank. Two instances run side by
// side: u_dut0 with RELOAD_ON_WRITE=0 and u_dut1 with RELOAD_ON_WRITE=1. A
// behavioural model of each channel tracks the expected outputs on every clock.
module tb_opsg_tone_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       phase_sync = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = 2'd0;
  logic [9:0] wr_data = 10'd0;
  logic [1:0] rd_ch = 2'd0;
  logic [9:0] rd0, rd1;
  logic [2:0] tone0, tone1, pulse0, pulse1;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;

  // Model state: [instance][channel]; instance 1 reloads on write.
  int m_freq  [2][3];
  int m_cnt   [2][3];
  int m_tone  [2][3];
  int m_pulse [2][3];
  int m_rd    [2];

  always #5 clk = ~clk;

  opsg_tone_bank #(.TONE_WIDTH(10), .NUM_CH(3), .CH_BITS(2), .RELOAD_ON_WRITE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .phase_sync(phase_sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .rd_ch(rd_ch), .rd_count(rd0),
    .tone_bits(tone0), .toggle_pulse(pulse0));

  opsg_tone_bank #(.TONE_WIDTH(10), .NUM_CH(3), .CH_BITS(2), .RELOAD_ON_WRITE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .phase_sync(phase_sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .rd_ch(rd_ch), .rd_count(rd1),
    .tone_bits(tone1), .toggle_pulse(pulse1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        m_freq[k][c] = 0; m_cnt[k][c] = 0; m_tone[k][c] = 1; m_pulse[k][c] = 0;
      end
      m_rd[k] = 0;
    end
  endtask

  // One clock edge of the model, using the inputs that were present at that edge.
  task automatic model_step();
    int  old_f;
    bit  wv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      m_rd[k] = (int'(rd_ch) < 3) ? m_cnt[k][int'(rd_ch)] : 0;
      for (int c = 0; c < 3; c++) begin
        old_f = m_freq[k][c];
        wv = wr_en && (int'(wr_ch) == c);
        m_pulse[k][c] = 0;
        if (phase_sync) begin
          m_cnt[k][c] = 0;
          m_tone[k][c] = 1;
        end else if (k == 1 && wv) begin
          m_cnt[k][c] = int'(wr_data);
        end else if (ce) begin
          if (m_cnt[k][c] > 0) begin
            m_cnt[k][c] = m_cnt[k][c] - 1;
          end else begin
            m_cnt[k][c] = old_f;
            if (old_f == 0) begin
              m_tone[k][c] = 1;
            end else begin
              m_tone[k][c] = 1 - m_tone[k][c];
              m_pulse[k][c] = 1;
            end
          end
        end
        if (wv) m_freq[k][c] = int'(wr_data);
      end
    end
  endtask

  function automatic logic [2:0] m_vec(input int k, input bit want_pulse);
    logic [2:0] v;
    for (int c = 0; c < 3; c++) v[c] = want_pulse ? m_pulse[k][c][0] : m_tone[k][c][0];
    return v;
  endfunction

  // Advance one clock, update the model, then compare every output of both instances.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    cyc_n++;
    chk("d0_tone",  {29'd0, tone0},  {29'd0, m_vec(0, 1'b0)});
    chk("d0_pulse", {29'd0, pulse0}, {29'd0, m_vec(0, 1'b1)});
    chk("d0_rd",    {22'd0, rd0},    m_rd[0]);
    chk("d1_tone",  {29'd0, tone1},  {29'd0, m_vec(1, 1'b0)});
    chk("d1_pulse", {29'd0, pulse1}, {29'd0, m_vec(1, 1'b1)});
    chk("d1_rd",    {22'd0, rd1},    m_rd[1]);
  endtask

  initial begin
    int p0, p12, last, n_int, guard;
    model_reset();

    // Reset state
    repeat (3) cyc();
    chk("rst_tone",  {29'd0, tone0},  32'd7);
    chk("rst_pulse", {29'd0, pulse0}, 32'd0);
    chk("rst_rd",    {22'd0, rd0},    32'd0);
    rst_n = 1'b1;

    // ch0 freq=3, ce held high
    wr_en = 1'b1; wr_ch = 2'd0; wr_data = 10'd3;
    cyc();
    wr_en = 1'b0; ce = 1'b1;
    cyc();
    chk("ch0_first_tone",  {31'd0, tone0[0]},  32'd0);
    chk("ch0_first_pulse", {31'd0, pulse0[0]}, 32'd1);
    p0 = 1; p12 = 0; last = cyc_n;
    for (int j = 0; j < 15; j++) begin
      cyc();
      if (pulse0[0]) begin
        chk("ch0_halfper", cyc_n - last, 32'd4);
        last = cyc_n; p0++;
      end
      if (pulse0[2:1] != 2'b00) p12++;
    end
    chk("ch0_pulse_cnt", p0,  32'd4);
    chk("ch12_quiet",    p12, 32'd0);

    // ch1 freq=0 with ce 1-in-4, then freq=2
    for (int j = 0; j < 16; j++) begin
      ce = (j % 4 == 0);
      cyc();
      chk("ch1_hold", {31'd0, tone0[1]}, 32'd1);
    end
    ce = 1'b0; wr_en = 1'b1; wr_ch = 2'd1; wr_data = 10'd2;
    cyc();
    wr_en = 1'b0;
    last = -1; n_int = 0;
    for (int j = 0; j < 72; j++) begin
      ce = (j % 4 == 0);
      cyc();
      if (pulse0[1]) begin
        if (last >= 0) begin
          chk("ch1_halfper", cyc_n - last, 32'd12);
          n_int++;
        end
        last = cyc_n;
      end
    end
    chk("ch1_intervals", {31'd0, n_int >= 4}, 32'd1);

    // ch2 write lands on the edge where its counter reloads (old freq=1)
    ce = 1'b0; wr_en = 1'b1; wr_ch = 2'd2; wr_data = 10'd1;
    cyc();
    wr_en = 1'b0; ce = 1'b1; rd_ch = 2'd2;
    guard = 0;
    do begin
      cyc(); guard++;
    end while (!(guard >= 2 && m_cnt[0][2] == 0) && guard < 10);
    chk("ch2_align", {31'd0, m_cnt[0][2] == 0}, 32'd1);
    wr_en = 1'b1; wr_data = 10'd5;
    cyc();
    wr_en = 1'b0;
    chk("ch2_d0_pulse",   {31'd0, pulse0[2]}, 32'd1);
    chk("ch2_d1_nopulse", {31'd0, pulse1[2]}, 32'd0);
    cyc();
    chk("ch2_d0_oldfreq", {22'd0, rd0}, 32'd1);
    chk("ch2_d1_loaded",  {22'd0, rd1}, 32'd5);
    repeat (14) cyc();

    // phase_sync while running
    repeat (3) cyc();
    phase_sync = 1'b1;
    cyc();
    phase_sync = 1'b0; ce = 1'b0;
    chk("ps_tone0",  {29'd0, tone0},  32'd7);
    chk("ps_tone1",  {29'd0, tone1},  32'd7);
    chk("ps_pulse0", {29'd0, pulse0}, 32'd0);
    for (int r = 0; r < 3; r++) begin
      rd_ch = 2'(r);
      cyc();
      chk("ps_rd0", {22'd0, rd0}, 32'd0);
      chk("ps_rd1", {22'd0, rd1}, 32'd0);
    end
    ce = 1'b1;
    cyc();
    ce = 1'b0;
    chk("ps_together_pulse", {29'd0, pulse0}, 32'd7);
    chk("ps_together_tone",  {29'd0, tone0},  32'd0);
    chk("ps_together_d1",    {29'd0, pulse1}, 32'd7);

    // Out-of-range write and readback
    wr_en = 1'b1; wr_ch = 2'd3; wr_data = 10'd7;
    cyc();
    wr_en = 1'b0; rd_ch = 2'd3; ce = 1'b1;
    cyc();
    chk("rd_oob0", {22'd0, rd0}, 32'd0);
    chk("rd_oob1", {22'd0, rd1}, 32'd0);
    repeat (12) cyc();

    // Randomized traffic
    for (int j = 0; j < 400; j++) begin
      ce         = 1'($urandom_range(0, 1));
      wr_en      = ($urandom_range(0, 7) == 0);
      wr_ch      = 2'($urandom_range(0, 3));
      wr_data    = 10'($urandom_range(0, 15));
      rd_ch      = 2'($urandom_range(0, 3));
      phase_sync = ($urandom_range(0, 31) == 0);
      cyc();
    end
    phase_sync = 1'b0;

    // Maximum frequency on ch0
    ce = 1'b0; wr_en = 1'b1; wr_ch = 2'd0; wr_data = 10'd1023;
    cyc();
    wr_en = 1'b0; ce = 1'b1; rd_ch = 2'd0;
    last = -1; n_int = 0;
    for (int j = 0; j < 2100; j++) begin
      cyc();
      if (pulse0[0]) begin
        if (last >= 0) begin
          chk("ch0_max_halfper", cyc_n - last, 32'd1024);
          n_int++;
        end
        last = cyc_n;
      end
    end
    chk("ch0_max_seen", {31'd0, n_int >= 1}, 32'd1);

    // Asynchronous reset mid-count
    repeat (5) cyc();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_tone0",  {29'd0, tone0},  32'd7);
    chk("arst_pulse0", {29'd0, pulse0}, 32'd0);
    chk("arst_rd0",    {22'd0, rd0},    32'd0);
    chk("arst_tone1",  {29'd0, tone1},  32'd7);
    chk("arst_rd1",    {22'd0, rd1},    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
